// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receive path.
//   i2s_state_e       : receiver FSM states
//   I2S_LEFT          : lrclk level that marks the left channel
//   I2S_DEFAULT_WIDTH : default captured bits per channel
package i2s_pkg;

  typedef enum logic [1:0] {
    StSync,
    StSkip,
    StShift,
    StPad
  } i2s_state_e;

  localparam logic I2S_LEFT = 1'b0;

  localparam int unsigned I2S_DEFAULT_WIDTH = 24;

endpackage

// File: rtl/i2s_sync.sv
// Two-flop synchronizer with an optional registered rising-edge pulse.
//   clk    : sampling clock
//   rst_n  : asynchronous active-low reset
//   d_i    : asynchronous input
//   q_o    : synchronized level, delayed one extra flop to line up with rise_o
//   rise_o : one-cycle pulse on a synchronized 0->1 (tied low when EdgeEn = 0)
module i2s_sync
  import i2s_pkg::*;
#(
  parameter bit EdgeEn = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);

  // [0],[1] form the synchronizer; [2] is the edge-detect history stage.
  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], d_i};
    end
  end

  // Taking the level from the history stage keeps every instance at the same
  // depth, so a data level is valid in the same cycle the registered bclk
  // edge pulse is seen.
  assign q_o = sync_q[2];

  if (EdgeEn) begin : g_edge
    logic rise_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rise_q <= 1'b0;
      end else begin
        rise_q <= sync_q[1] & ~sync_q[2];
      end
    end
    assign rise_o = rise_q;
  end else begin : g_no_edge
    assign rise_o = 1'b0;
  end

endmodule

// File: rtl/i2s_rx.sv
// I2S receive deserializer. Oversamples bclk/lrclk/sdata with clk, captures
// WIDTH bits per channel MSB first, and offers each stereo pair over a
// valid/ready handshake.
//   clk, cpu_resetn       : system clock, asynchronous active-low reset
//   bclk, lrclk, sdata    : I2S bus from the codec ADC (asynchronous)
//   enable                : 0 holds the receiver in sync-search
//   out_valid/out_ready   : pair handshake
//   out_l, out_r          : left/right samples, two's complement
//   overrun, frame_err    : sticky error flags, cleared by clr_flags
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int unsigned WIDTH = I2S_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             cpu_resetn,
  input  logic             bclk,
  input  logic             lrclk,
  input  logic             sdata,
  input  logic             enable,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_l,
  output logic [WIDTH-1:0] out_r,
  output logic             overrun,
  output logic             frame_err,
  input  logic             clr_flags
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic bclk_rise;
  logic lr_s;
  logic sd_s;
  logic unused_bclk_lvl;
  logic unused_lr_rise;
  logic unused_sd_rise;

  i2s_sync #(.EdgeEn(1'b1)) u_sync_bclk (
    .clk    (clk),
    .rst_n  (cpu_resetn),
    .d_i    (bclk),
    .q_o    (unused_bclk_lvl),
    .rise_o (bclk_rise)
  );

  i2s_sync #(.EdgeEn(1'b0)) u_sync_lrclk (
    .clk    (clk),
    .rst_n  (cpu_resetn),
    .d_i    (lrclk),
    .q_o    (lr_s),
    .rise_o (unused_lr_rise)
  );

  i2s_sync #(.EdgeEn(1'b0)) u_sync_sdata (
    .clk    (clk),
    .rst_n  (cpu_resetn),
    .d_i    (sdata),
    .q_o    (sd_s),
    .rise_o (unused_sd_rise)
  );

  i2s_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             chan_q, chan_d;
  logic             lr_prev_q, lr_prev_d;
  logic             left_ok_q, left_ok_d;
  logic [WIDTH-1:0] sh_l_q, sh_l_d;
  logic [WIDTH-1:0] sh_r_q, sh_r_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_l_q, out_l_d;
  logic [WIDTH-1:0] out_r_q, out_r_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;

  logic             lr_chg;
  logic             word_start;
  logic [CntW-1:0]  cnt_inc;
  logic             last_bit;
  logic             pair_done;
  logic             ferr_set;
  logic             ovr_set;

  // lr_prev_q holds lrclk as sampled on the previous bclk rise.
  assign lr_chg     = lr_s != lr_prev_q;
  assign word_start = lr_prev_q && (lr_s == I2S_LEFT);
  assign cnt_inc    = cnt_q + 1'b1;
  assign last_bit   = cnt_inc == CntW'(WIDTH);

  // State register.
  always_ff @(posedge clk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      state_q <= StSync;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state. StSkip is entered on the rise that carries the one-bit delay
  // slot, so that bit is never shifted; the following rise holds the MSB.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = StSync;
    end else if (bclk_rise) begin
      unique case (state_q)
        StSync: begin
          if (word_start) state_d = StSkip;
        end
        StSkip, StShift: begin
          if (lr_chg) begin
            state_d = StSkip;
          end else if (last_bit) begin
            state_d = StPad;
          end else begin
            state_d = StShift;
          end
        end
        StPad: begin
          if (lr_chg) state_d = StSkip;
        end
        default: state_d = StSync;
      endcase
    end
  end

  // Datapath and output handshake.
  always_comb begin
    cnt_d     = cnt_q;
    chan_d    = chan_q;
    left_ok_d = left_ok_q;
    sh_l_d    = sh_l_q;
    sh_r_d    = sh_r_q;
    pair_done = 1'b0;
    ferr_set  = 1'b0;
    lr_prev_d = bclk_rise ? lr_s : lr_prev_q;

    if (!enable) begin
      cnt_d     = '0;
      left_ok_d = 1'b0;
      sh_l_d    = '0;
      sh_r_d    = '0;
    end else if (bclk_rise) begin
      unique case (state_q)
        StSync: begin
          if (word_start) begin
            cnt_d  = '0;
            chan_d = I2S_LEFT;
          end
        end
        StSkip, StShift: begin
          if (lr_chg) begin
            // Short word: drop the partial word and resync on the new channel.
            ferr_set  = 1'b1;
            left_ok_d = 1'b0;
            cnt_d     = '0;
            chan_d    = lr_s;
          end else begin
            cnt_d = cnt_inc;
            if (chan_q == I2S_LEFT) begin
              sh_l_d = {sh_l_q[WIDTH-2:0], sd_s};
            end else begin
              sh_r_d = {sh_r_q[WIDTH-2:0], sd_s};
            end
            if (last_bit) begin
              if (chan_q == I2S_LEFT) begin
                left_ok_d = 1'b1;
              end else if (left_ok_q) begin
                pair_done = 1'b1;
                left_ok_d = 1'b0;
              end
            end
          end
        end
        StPad: begin
          // Counter stays saturated at WIDTH while slot padding goes by.
          if (lr_chg) begin
            cnt_d  = '0;
            chan_d = lr_s;
          end
        end
        default: ;
      endcase
    end

    out_valid_d = out_valid_q;
    out_l_d     = out_l_q;
    out_r_d     = out_r_q;
    ovr_set     = 1'b0;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (pair_done) begin
      if (!out_valid_q || out_ready) begin
        out_valid_d = 1'b1;
        out_l_d     = sh_l_q;
        out_r_d     = sh_r_d;
      end else begin
        ovr_set = 1'b1;
      end
    end

    // A set in the same cycle as clr_flags wins.
    overrun_d   = (overrun_q & ~clr_flags) | ovr_set;
    frame_err_d = (frame_err_q & ~clr_flags) | ferr_set;
  end

  always_ff @(posedge clk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      cnt_q       <= '0;
      chan_q      <= I2S_LEFT;
      lr_prev_q   <= 1'b0;
      left_ok_q   <= 1'b0;
      sh_l_q      <= '0;
      sh_r_q      <= '0;
      out_valid_q <= 1'b0;
      out_l_q     <= '0;
      out_r_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      chan_q      <= chan_d;
      lr_prev_q   <= lr_prev_d;
      left_ok_q   <= left_ok_d;
      sh_l_q      <= sh_l_d;
      sh_r_q      <= sh_r_d;
      out_valid_q <= out_valid_d;
      out_l_q     <= out_l_d;
      out_r_q     <= out_r_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_l     = out_l_q;
  assign out_r     = out_r_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_i2s_rx.sv
module tb_i2s_rx;

  localparam int W = 24;
  localparam int H = 160;  // bclk half period in ns (16 clk cycles)

  logic         clk = 1'b0;
  logic         cpu_resetn;
  logic         bclk;
  logic         lrclk;
  logic         sdata;
  logic         enable;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_l;
  logic [W-1:0] out_r;
  logic         overrun;
  logic         frame_err;
  logic         clr_flags;

  always #5 clk = ~clk;

  i2s_rx #(.WIDTH(W)) dut (
    .clk        (clk),
    .cpu_resetn (cpu_resetn),
    .bclk       (bclk),
    .lrclk      (lrclk),
    .sdata      (sdata),
    .enable     (enable),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_l      (out_l),
    .out_r      (out_r),
    .overrun    (overrun),
    .frame_err  (frame_err),
    .clr_flags  (clr_flags)
  );

  int n_vec = 0;
  int n_err = 0;

  // Serial line state: bit shifted out at the next slot's first rise.
  logic carry = 1'b0;

  // Slot-level reference model.
  logic [2*W-1:0] exp_q[$];
  bit             m_en       = 1'b1;
  bit             m_sync     = 1'b0;
  bit             m_prev_ok  = 1'b1;
  bit             m_left_ok  = 1'b0;
  bit             m_last_lr  = 1'b0;
  bit             m_ferr     = 1'b0;
  bit             m_ovr      = 1'b0;
  logic [W-1:0]   m_left     = '0;
  logic [W-1:0]   lat_l, lat_r;

  logic [W-1:0]   rl, rr;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Applies the protocol rules to a whole slot before it is transmitted.
  task automatic model_slot(input bit lr, input int len, input logic [31:0] word);
    bit           complete;
    logic [W-1:0] val;
    m_last_lr = lr;
    if (!m_en) begin
      m_sync    = 1'b0;
      m_left_ok = 1'b0;
      return;
    end
    if (m_sync) begin
      if (!m_prev_ok) begin
        m_ferr    = 1'b1;
        m_left_ok = 1'b0;
      end
    end else if (lr == 1'b0) begin
      m_sync = 1'b1;
    end else begin
      return;
    end
    complete  = (len - 1) >= W;
    m_prev_ok = complete;
    val       = word[31 -: W];
    if (complete) begin
      if (lr == 1'b0) begin
        m_left_ok = 1'b1;
        m_left    = val;
      end else if (m_left_ok) begin
        m_left_ok = 1'b0;
        if (!out_ready && exp_q.size() > 0) m_ovr = 1'b1;
        else exp_q.push_back({m_left, val});
      end
    end
  endtask

  // Drives one slot: lrclk/sdata change with bclk falling, MSB one bit late.
  task automatic send_slot(input bit lr, input int len, input logic [31:0] word,
                           input int lat_pos, input int en_at);
    for (int i = 0; i < len; i++) begin
      bclk  = 1'b0;
      lrclk = lr;
      sdata = carry;
      carry = (i < 32) ? word[31-i] : 1'b0;
      if (i == en_at) enable = 1'b1;
      #H;
      bclk = 1'b1;
      if (i == lat_pos) begin
        fork
          #H;
          begin
            repeat (3) @(posedge clk);
            #1 check("lat_c3_valid", 48'(out_valid), 48'd0);
            @(posedge clk);
            #1 check("lat_c4_valid", 48'(out_valid), 48'd1);
            check("lat_c4_l", 48'(out_l), 48'(lat_l));
            check("lat_c4_r", 48'(out_r), 48'(lat_r));
            @(posedge clk);
            #1 check("lat_c5_valid", 48'(out_valid), 48'd0);
          end
        join
      end else begin
        #H;
      end
    end
  endtask

  task automatic send_frame(input logic [31:0] lw, input logic [31:0] rw,
                            input int llen, input int lat_pos);
    model_slot(1'b0, llen, lw);
    send_slot(1'b0, llen, lw, -1, -1);
    model_slot(1'b1, 32, rw);
    send_slot(1'b1, 32, rw, lat_pos, -1);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Every accepted pair must be the next one the model expects.
  always @(negedge clk) begin
    if (cpu_resetn && out_valid && out_ready) begin
      check("pair_expected", 48'(exp_q.size() != 0), 48'd1);
      if (exp_q.size() != 0) check("pair_data", {out_l, out_r}, exp_q.pop_front());
    end
  end

  initial begin
    cpu_resetn = 1'b0;
    bclk       = 1'b0;
    lrclk      = 1'b1;
    sdata      = 1'b0;
    enable     = 1'b1;
    out_ready  = 1'b1;
    clr_flags  = 1'b0;
    repeat (3) cyc();
    check("rst_valid", 48'(out_valid), 48'd0);
    check("rst_l", 48'(out_l), 48'd0);
    check("rst_r", 48'(out_r), 48'd0);
    check("rst_ovr", 48'(overrun), 48'd0);
    check("rst_ferr", 48'(frame_err), 48'd0);
    cpu_resetn = 1'b1;
    repeat (3) cyc();

    // Junk right slot: receiver still searching for a left word.
    model_slot(1'b1, 32, 32'hDEADBEEF);
    send_slot(1'b1, 32, 32'hDEADBEEF, -1, -1);

    // Single frame with latency check on the right word's last captured bit.
    lat_l = 24'hABCDEF;
    lat_r = 24'h123456;
    send_frame({lat_l, 8'h00}, {lat_r, 8'h00}, 32, W);

    // Random frames.
    for (int k = 0; k < 3; k++) begin
      rl = W'($urandom);
      rr = W'($urandom);
      send_frame({rl, 8'(k)}, {rr, 8'($urandom)}, 32, -1);
    end

    // Short left word, then an intact frame.
    rl = W'($urandom);
    rr = W'($urandom);
    send_frame({rl, 8'h00}, {rr, 8'h00}, 17, -1);
    send_frame({24'h7FFFFF, 8'h00}, {24'h800000, 8'h00}, 32, -1);
    cyc();
    check("short_ferr", 48'(frame_err), 48'(m_ferr));
    clr_flags = 1'b1;
    cyc();
    clr_flags = 1'b0;
    m_ferr    = 1'b0;
    check("short_ferr_clr", 48'(frame_err), 48'(m_ferr));

    // Slot padding: trailing ones in a 32-bit slot must be ignored.
    rr = W'($urandom);
    send_frame({24'h5A5A5A, 8'hFF}, {rr, 8'hFF}, 32, -1);
    cyc();
    check("pad_ferr", 48'(frame_err), 48'(m_ferr));

    // Backpressure across two pairs.
    out_ready = 1'b0;
    send_frame({24'd1, 8'h00}, {24'd2, 8'h00}, 32, -1);
    send_frame({24'd3, 8'h00}, {24'd4, 8'h00}, 32, -1);
    cyc();
    check("bp_valid", 48'(out_valid), 48'd1);
    check("bp_l", 48'(out_l), 48'd1);
    check("bp_r", 48'(out_r), 48'd2);
    check("bp_ovr", 48'(overrun), 48'(m_ovr));
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    clr_flags = 1'b1;
    cyc();
    clr_flags = 1'b0;
    m_ovr     = 1'b0;
    cyc();
    check("bp_valid_after", 48'(out_valid), 48'd0);
    check("bp_ovr_clr", 48'(overrun), 48'(m_ovr));
    out_ready = 1'b1;

    // Enable rises in the middle of a right word.
    enable = 1'b0;
    m_en   = 1'b0;
    rl = W'($urandom);
    rr = W'($urandom);
    model_slot(1'b0, 32, {rl, 8'h00});
    send_slot(1'b0, 32, {rl, 8'h00}, -1, -1);
    model_slot(1'b1, 32, {rr, 8'h00});
    send_slot(1'b1, 32, {rr, 8'h00}, -1, 8);
    m_en = 1'b1;
    check("en_no_pair", 48'(out_valid), 48'd0);
    rl = W'($urandom);
    rr = W'($urandom);
    send_frame({rl, 8'h00}, {rr, 8'h00}, 32, -1);

    // Reset mid-stream with a held pair and a set flag.
    out_ready = 1'b0;
    send_frame({24'd5, 8'h00}, {24'd6, 8'h00}, 32, -1);
    send_frame({24'd7, 8'h00}, {24'd8, 8'h00}, 32, -1);
    model_slot(1'b0, 32, 32'h11223344);
    send_slot(1'b0, 32, 32'h11223344, -1, -1);
    check("pre_rst_valid", 48'(out_valid), 48'd1);
    #3 cpu_resetn = 1'b0;
    #1;
    check("mid_rst_valid", 48'(out_valid), 48'd0);
    check("mid_rst_l", 48'(out_l), 48'd0);
    check("mid_rst_r", 48'(out_r), 48'd0);
    check("mid_rst_ovr", 48'(overrun), 48'd0);
    check("mid_rst_ferr", 48'(frame_err), 48'd0);
    exp_q.delete();
    m_sync    = 1'b0;
    m_left_ok = 1'b0;
    m_ovr     = 1'b0;
    m_ferr    = 1'b0;
    m_last_lr = 1'b0;
    cyc();
    cpu_resetn = 1'b1;
    out_ready  = 1'b1;
    cyc();
    model_slot(1'b1, 32, 32'h55667788);
    send_slot(1'b1, 32, 32'h55667788, -1, -1);
    check("post_rst_no_pair", 48'(out_valid), 48'd0);
    rl = W'($urandom);
    rr = W'($urandom);
    send_frame({rl, 8'h00}, {rr, 8'h00}, 32, -1);

    repeat (20) cyc();
    check("queue_drained", 48'(exp_q.size()), 48'd0);
    check("end_ferr", 48'(frame_err), 48'(m_ferr));
    check("end_ovr", 48'(overrun), 48'(m_ovr));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
